// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI4-Lite initiator driven by a command/response handshake
module axi_lite_cmd_master #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

    // Counter is wide enough to hold TIMEOUT; a 1-bit dummy keeps widths legal when disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_hit, take_timeout;

    logic               cmd_ready_d, rsp_valid_d, rsp_timeout_d, busy_d;
    logic [31:0]        rsp_rdata_d, wdata_d;
    logic [1:0]         rsp_resp_d;
    logic [ADDR_W-1:0]  awaddr_d, araddr_d;
    logic               awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

    // Next state and next values of every registered output; all outputs come straight from flops.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        take_timeout  = 1'b0;
        cmd_ready_d   = cmd_ready;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        awaddr_d      = M_AXI_AWADDR;
        awvalid_d     = M_AXI_AWVALID;
        wdata_d       = M_AXI_WDATA;
        wvalid_d      = M_AXI_WVALID;
        bready_d      = M_AXI_BREADY;
        araddr_d      = M_AXI_ARADDR;
        arvalid_d     = M_AXI_ARVALID;
        rready_d      = M_AXI_RREADY;
        timeout_hit   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_AW_W;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_AR;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                // AW and W retire independently; the phase ends once neither is still pending.
                awvalid_d = M_AXI_AWVALID && !M_AXI_AWREADY;
                wvalid_d  = M_AXI_WVALID && !M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end else if (timeout_hit) begin
                    take_timeout = 1'b1;
                end
            end
            WR_B: begin
                if (M_AXI_BVALID) begin
                    state_d       = RSP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = M_AXI_BRESP;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    take_timeout = 1'b1;
                end
            end
            RD_AR: begin
                if (M_AXI_ARREADY) begin
                    state_d   = RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (timeout_hit) begin
                    take_timeout = 1'b1;
                end
            end
            RD_R: begin
                if (M_AXI_RVALID) begin
                    state_d       = RSP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = M_AXI_RRESP;
                    rsp_rdata_d   = M_AXI_RDATA;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    take_timeout = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled phase abandons the bus and reports SLVERR with the timeout flag.
        if (take_timeout) begin
            state_d       = RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
        end

        // Phase counter restarts on every state change and saturates instead of wrapping.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE && state_q != RSP && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // State, counter and all output registers; reset drops every VALID/READY immediately.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            rsp_timeout   <= 1'b0;
            busy          <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready     <= cmd_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            rsp_timeout   <= rsp_timeout_d;
            busy          <= busy_d;
            M_AXI_AWADDR  <= awaddr_d;
            M_AXI_AWVALID <= awvalid_d;
            M_AXI_WDATA   <= wdata_d;
            M_AXI_WVALID  <= wvalid_d;
            M_AXI_BREADY  <= bready_d;
            M_AXI_ARADDR  <= araddr_d;
            M_AXI_ARVALID <= arvalid_d;
            M_AXI_RREADY  <= rready_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - directed self-checking bench for axi_lite_cmd_master
module tb_axi_lite_cmd_master;

    logic        clk = 1'b0;
    logic        M_AXI_ARESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int total = 0;
    int bad = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(.ADDR_W(4), .TIMEOUT(16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(M_AXI_ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Handshake counters seen on the bus
    always @(posedge clk) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs <= aw_hs + 1;
        if (M_AXI_WVALID && M_AXI_WREADY) w_hs <= w_hs + 1;
        if (M_AXI_ARVALID && M_AXI_ARREADY) ar_hs <= ar_hs + 1;
        if (M_AXI_BVALID && M_AXI_BREADY) b_hs <= b_hs + 1;
        if (M_AXI_RVALID && M_AXI_RREADY) r_hs <= r_hs + 1;
    end

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BRESP = 0; M_AXI_BVALID = 0;
        M_AXI_ARREADY = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 0; M_AXI_RVALID = 0;
    endtask

    task automatic test_reset();
        M_AXI_ARESETN = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%0b exp=0", cmd_ready); end
        total++; if ({rsp_valid, rsp_timeout, busy} !== 3'b000) begin bad++; $display("FAIL rst_rsp_flags got=%b exp=000", {rsp_valid, rsp_timeout, busy}); end
        total++; if ({rsp_rdata, rsp_resp} !== 34'd0) begin bad++; $display("FAIL rst_rsp_data got=%h exp=0", {rsp_rdata, rsp_resp}); end
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin bad++; $display("FAIL rst_axi_ctrl got=%b exp=00000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}); end
        total++; if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA} !== 40'd0) begin bad++; $display("FAIL rst_axi_data got=%h exp=0", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA}); end
        M_AXI_ARESETN = 1;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_release_cmd_ready got=%0b exp=0", cmd_ready); end
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_first_edge_cmd_ready got=%0b exp=1", cmd_ready); end
    endtask

    task automatic test_write();
        int aw0, w0;
        aw0 = aw_hs; w0 = w_hs;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h4; cmd_wdata = 32'h0000_0041;
        M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        @(negedge clk);
        cmd_valid = 0;
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, busy} !== 4'b1101) begin bad++; $display("FAIL wr_valids got=%b exp=1101", {M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, busy}); end
        total++; if ({M_AXI_AWADDR, M_AXI_WDATA} !== {4'h4, 32'h0000_0041}) begin bad++; $display("FAIL wr_addr_data got=%h exp=400000041", {M_AXI_AWADDR, M_AXI_WDATA}); end
        @(negedge clk);
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid} !== 4'b0010) begin bad++; $display("FAIL wr_bphase got=%b exp=0010", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid}); end
        total++; if ((aw_hs - aw0) != 1 || (w_hs - w0) != 1) begin bad++; $display("FAIL wr_hs_count got=%0d/%0d exp=1/1", aw_hs - aw0, w_hs - w0); end
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
        @(negedge clk);
        M_AXI_BVALID = 0;
        total++; if ({rsp_valid, rsp_timeout, M_AXI_BREADY} !== 3'b100) begin bad++; $display("FAIL wr_rsp_valid_n3 got=%b exp=100", {rsp_valid, rsp_timeout, M_AXI_BREADY}); end
        total++; if ({rsp_resp, rsp_rdata} !== 34'd0) begin bad++; $display("FAIL wr_rsp_data got=%h exp=0", {rsp_resp, rsp_rdata}); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        total++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin bad++; $display("FAIL wr_after_rsp got=%b exp=010", {rsp_valid, cmd_ready, busy}); end
    endtask

    task automatic test_read();
        int errs = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h0;
        M_AXI_ARREADY = 1;
        @(negedge clk);
        cmd_valid = 0;
        total++; if ({M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_AWVALID} !== {1'b1, 4'h0, 1'b0}) begin bad++; $display("FAIL rd_ar got=%b exp=100000", {M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_AWVALID}); end
        @(negedge clk);
        M_AXI_ARREADY = 0;
        total++; if ({M_AXI_ARVALID, M_AXI_RREADY} !== 2'b01) begin bad++; $display("FAIL rd_rphase got=%b exp=01", {M_AXI_ARVALID, M_AXI_RREADY}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (M_AXI_RREADY !== 1'b1 || rsp_valid !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL rd_rready_hold got=%0d bad cycles exp=0", errs); end
        M_AXI_RVALID = 1; M_AXI_RDATA = 32'h0000_005A; M_AXI_RRESP = 2'b00;
        @(negedge clk);
        M_AXI_RVALID = 0; M_AXI_RDATA = 32'hFFFF_FFFF;
        total++; if ({rsp_valid, M_AXI_RREADY, rsp_timeout} !== 3'b100) begin bad++; $display("FAIL rd_rsp_flags got=%b exp=100", {rsp_valid, M_AXI_RREADY, rsp_timeout}); end
        total++; if ({rsp_rdata, rsp_resp} !== {32'h0000_005A, 2'b00}) begin bad++; $display("FAIL rd_rsp_data got=%h/%b exp=0000005a/00", rsp_rdata, rsp_resp); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_skewed_write();
        int aw0, w0, errs = 0;
        aw0 = aw_hs; w0 = w_hs;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h8; cmd_wdata = 32'hDEAD_BEEF;
        M_AXI_AWREADY = 1; M_AXI_WREADY = 0;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        M_AXI_AWREADY = 0;
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b010) begin bad++; $display("FAIL sk_aw_drop got=%b exp=010", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (M_AXI_WVALID !== 1'b1 || M_AXI_WDATA !== 32'hDEAD_BEEF || M_AXI_BREADY !== 1'b0 || M_AXI_AWVALID !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL sk_w_hold got=%0d bad cycles exp=0", errs); end
        M_AXI_WREADY = 1;
        @(negedge clk);
        M_AXI_WREADY = 0;
        total++; if ({M_AXI_WVALID, M_AXI_BREADY, M_AXI_AWADDR} !== {2'b01, 4'h8}) begin bad++; $display("FAIL sk_bready got=%b exp=011000", {M_AXI_WVALID, M_AXI_BREADY, M_AXI_AWADDR}); end
        total++; if ((aw_hs - aw0) != 1 || (w_hs - w0) != 1) begin bad++; $display("FAIL sk_hs_count got=%0d/%0d exp=1/1", aw_hs - aw0, w_hs - w0); end
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
        @(negedge clk);
        M_AXI_BVALID = 0;
        total++; if ({rsp_valid, rsp_resp} !== 3'b100) begin bad++; $display("FAIL sk_rsp got=%b exp=100", {rsp_valid, rsp_resp}); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_timeout();
        int errs = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h2;
        M_AXI_ARREADY = 0;
        @(negedge clk);
        cmd_valid = 0;
        for (int i = 0; i < 16; i++) begin
            if (M_AXI_ARVALID !== 1'b1 || rsp_valid !== 1'b0) errs++;
            @(negedge clk);
        end
        total++; if (errs != 0) begin bad++; $display("FAIL to_arvalid_16 got=%0d bad cycles exp=0", errs); end
        total++; if ({M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, rsp_timeout} !== 4'b0011) begin bad++; $display("FAIL to_fire got=%b exp=0011", {M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, rsp_timeout}); end
        total++; if ({rsp_resp, rsp_rdata} !== {2'b10, 32'd0}) begin bad++; $display("FAIL to_rsp_data got=%b/%h exp=10/00000000", rsp_resp, rsp_rdata); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        total++; if ({cmd_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL to_recover got=%b exp=10", {cmd_ready, rsp_valid}); end
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h6;
        M_AXI_ARREADY = 1;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        M_AXI_ARREADY = 0;
        M_AXI_RVALID = 1; M_AXI_RDATA = 32'h0000_1234; M_AXI_RRESP = 2'b00;
        @(negedge clk);
        M_AXI_RVALID = 0;
        total++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'h0000_1234}) begin bad++; $display("FAIL to_next_cmd got=%b%b/%b/%h exp=10/00/00001234", rsp_valid, rsp_timeout, rsp_resp, rsp_rdata); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_backpressure();
        int errs = 0;
        int n = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'hC;
        M_AXI_ARREADY = 1; M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        @(negedge clk);
        total++; if (M_AXI_ARADDR !== 4'hC) begin bad++; $display("FAIL bp_araddr got=%h exp=c", M_AXI_ARADDR); end
        cmd_write = 1; cmd_addr = 4'h4; cmd_wdata = 32'h0000_0055;
        @(negedge clk);
        M_AXI_ARREADY = 0;
        M_AXI_RVALID = 1; M_AXI_RDATA = 32'hCAFE_0001; M_AXI_RRESP = 2'b10;
        @(negedge clk);
        M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
        total++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {2'b10, 2'b10, 32'hCAFE_0001}) begin bad++; $display("FAIL bp_slverr got=%b%b/%b/%h exp=10/10/cafe0001", rsp_valid, rsp_timeout, rsp_resp, rsp_rdata); end
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0001 || rsp_resp !== 2'b10 || rsp_timeout !== 1'b0 || cmd_ready !== 1'b0 || M_AXI_AWVALID !== 1'b0 || busy !== 1'b1) errs++;
            @(negedge clk);
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles exp=0", errs); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        total++; if ({rsp_valid, cmd_ready, M_AXI_AWVALID} !== 3'b010) begin bad++; $display("FAIL bp_release got=%b exp=010", {rsp_valid, cmd_ready, M_AXI_AWVALID}); end
        @(negedge clk);
        cmd_valid = 0;
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA} !== {2'b11, 4'h4, 32'h0000_0055}) begin bad++; $display("FAIL bp_second_cmd got=%h exp=3400000055", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA}); end
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
        while (rsp_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        M_AXI_BVALID = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        total++; if ({rsp_valid, rsp_resp, rsp_timeout} !== 4'b1000) begin bad++; $display("FAIL bp_second_rsp got=%b after %0d cycles exp=1000", {rsp_valid, rsp_resp, rsp_timeout}, n); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid_write();
        int errs = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'hA; cmd_wdata = 32'h0000_0077;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        @(negedge clk);
        cmd_valid = 0;
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b11) begin bad++; $display("FAIL mr_pre got=%b exp=11", {M_AXI_AWVALID, M_AXI_WVALID}); end
        #2;
        M_AXI_ARESETN = 0;
        #1;
        total++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin bad++; $display("FAIL mr_async_drop got=%b exp=00000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}); end
        total++; if ({busy, rsp_valid, cmd_ready, M_AXI_AWADDR} !== 7'd0) begin bad++; $display("FAIL mr_async_state got=%b exp=0000000", {busy, rsp_valid, cmd_ready, M_AXI_AWADDR}); end
        repeat (2) @(negedge clk);
        M_AXI_ARESETN = 1;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL mr_release got=%0b exp=0", cmd_ready); end
        @(negedge clk);
        total++; if ({cmd_ready, busy} !== 2'b10) begin bad++; $display("FAIL mr_ready_back got=%b exp=10", {cmd_ready, busy}); end
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0 || M_AXI_AWVALID !== 1'b0) errs++;
            @(negedge clk);
        end
        total++; if (errs != 0) begin bad++; $display("FAIL mr_no_rsp got=%0d bad cycles exp=0", errs); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_skewed_write();
        test_timeout();
        test_backpressure();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into complete AXI4-Lite write or read transactions. It is the bus-driving end for our UART AXI4-Lite peripheral: test logic, VIO or a command parser issues register accesses through it instead of pulsing the UART core directly. It includes a per-phase timeout so a non-responding slave cannot hang the requester.

## Interface
- ADDR_W, 4, AXI address width (matches the UART slave register space)
- TIMEOUT, 1023, max cycles waited in any AXI handshake phase; 0 disables timeout

- M_AXI_ACLK  in  1  sole clock, all logic rising-edge
- M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command (IDLE only)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester consumes response
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_resp  out  2  captured BRESP/RRESP; 2'b10 on timeout
- rsp_timeout  out  1  response produced by timeout
- busy  out  1  high in every state except IDLE
- M_AXI_AWADDR out ADDR_W, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1
- M_AXI_WDATA out 32, M_AXI_WVALID out 1, M_AXI_WREADY in 1
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1
- M_AXI_ARADDR out ADDR_W, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1
- M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1

## Operation
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready latch write/addr/wdata; go WR_AW_W (write) or RD_AR (read).
- WR_AW_W: AWVALID and WVALID both high on entry; each deasserts independently the cycle after its own VALID&READY sample; AWADDR/WDATA held stable while respective VALID high. When both handshakes complete (same or different cycles) go WR_B.
- WR_B: BREADY=1; on BVALID capture BRESP, rsp_rdata=0, go RSP.
- RD_AR: ARVALID=1 until ARREADY sampled; go RD_R.
- RD_R: RREADY=1; on RVALID capture RDATA/RRESP, go RSP.
- RSP: rsp_valid=1, outputs stable until rsp_ready sampled high; then IDLE.
- Timeout: cycle counter clears on every state entry, increments in WR_AW_W, WR_B, RD_AR, RD_R. If TIMEOUT!=0 and counter reaches TIMEOUT: drop all AXI VALID/READY outputs, go RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0. Counter width = clog2(TIMEOUT+1); must not wrap.
- Never more than one transaction outstanding; cmd_valid outside IDLE is ignored (not accepted).
- Any RESP value (OKAY/SLVERR/DECERR) is passed through unmodified; block does not retry.

## Timing
- Reset (ARESETN low): state IDLE immediately; cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, busy=0, all AXI VALID/READY=0, AWADDR/ARADDR/WDATA=0. cmd_ready rises on first clock edge after deassertion.
- All outputs registered; no combinational path from any input to any output.
- Command accepted at edge N: AWVALID/WVALID (or ARVALID) high from N+1.
- Zero-wait slave (READY high, B/R returned next cycle): rsp_valid high at N+3 for reads and writes.
- rsp_valid high one cycle after final B or R handshake; cmd_ready high one cycle after rsp handshake (back-to-back command spacing ≥ 4 cycles).
- Reset mid-transaction: in-flight command discarded, no response generated, AXI VALIDs drop asynchronously.
- Timeout fires exactly TIMEOUT cycles after phase entry; rsp_valid the following cycle.

## Test plan
- Write: cmd addr 4'h4, wdata 32'h0000_0041, AWREADY/WREADY tied 1, BVALID 1 cycle later with BRESP 0 -> one AW and one W handshake with correct addr/data, rsp_valid at N+3, rsp_resp=0, rsp_rdata=0.
- Read: cmd addr 4'h0, slave returns RDATA 32'h0000_005A after 5 wait cycles on RVALID -> rsp_rdata=32'h5A, rsp_resp=0, RREADY held until handshake.
- Skewed write: AWREADY at N+1, WREADY at N+4 -> AWVALID low from N+2, WVALID held with stable WDATA until N+4, BREADY only after both.
- Timeout: TIMEOUT=16, ARREADY never asserted -> ARVALID drops after 16 cycles, rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0; next command accepted normally.
- Backpressure: rsp_ready low 10 cycles -> rsp_* stable, cmd_ready stays 0, second cmd_valid not accepted until response consumed; SLVERR from slave passed through as 2'b10 with rsp_timeout=0.
- Reset mid-write: deassert ARESETN while AWVALID high -> all VALIDs 0 immediately, no rsp_valid, cmd_ready returns 1 one edge after release.
